// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the tile-map video path.
//   - Raster timing constants: visible and total pixels per line, lines per frame.
//   - Tile-word field positions: char code, foreground colour, background colour.
//   - Tile-map geometry: 32 columns by 30 rows of 8x8 tiles.
//   - Prefetch window start and its phase offset.
//   - Helper that gives the line after a given line, wrapping at the frame end.
// -----------------------------------------------------------------------------
package video_pkg;

    // Raster timing
    localparam int H_DISPLAY = 256;
    localparam int H_TOTAL   = 309;
    localparam int V_DISPLAY = 240;
    localparam int V_TOTAL   = 262;

    // Tile-map geometry
    localparam int TILE_COLS = 32;
    localparam int TILE_ROWS = 30;

    // Tile RAM word layout (bits 11 and 15 are spare)
    localparam int CODE_LSB = 0;
    localparam int CODE_MSB = 7;
    localparam int FG_LSB   = 8;
    localparam int FG_MSB   = 10;
    localparam int BG_LSB   = 12;
    localparam int BG_MSB   = 14;

    // The column-0 prefetch occupies the last 8 clocks of every line.
    localparam logic [8:0] PREFETCH_START = 9'(H_TOTAL - 8);

    // H_TOTAL is not a multiple of 8, so hpos[2:0] is not 0 when the
    // prefetch window opens. This offset re-bases the phase inside that window.
    localparam logic [2:0] PREFETCH_PHASE = 3'(H_TOTAL - 8);

    // Attributes of the tile currently being fetched
    typedef struct packed {
        logic [7:0] code;
        logic [2:0] fg;
        logic [2:0] bg;
    } tile_attr_t;

    // Line that follows 'line', wrapping from the last line of the frame to 0
    function automatic logic [8:0] next_line(input logic [8:0] line);
        logic [8:0] result;
        if (line == 9'(V_TOTAL - 1)) begin
            result = 9'd0;
        end else begin
            result = line + 9'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tile_shifter.sv
// -----------------------------------------------------------------------------
// tile_shifter
// Pixel serialiser for one 8-pixel tile row, plus the colour attributes of the
// tile currently on screen.
//   clk, reset  : pixel clock and asynchronous active-high reset
//   load        : when high, take load_bits/load_fg/load_bg on this edge.
//                 When low, shift the bitmap left by one pixel.
//   load_bits   : bitmap row of the next tile; bit 7 is the leftmost pixel
//   load_fg/bg  : colours of the next tile
//   pixel_bit   : current pixel, which is the shift register MSB
//   cur_fg/bg   : colours of the tile on screen
// -----------------------------------------------------------------------------
module tile_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_bits,
    input  logic [2:0] load_fg,
    input  logic [2:0] load_bg,
    output logic       pixel_bit,
    output logic [2:0] cur_fg,
    output logic [2:0] cur_bg
);

    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] fg_q;
    logic [2:0] fg_d;
    logic [2:0] bg_q;
    logic [2:0] bg_d;

    // Next-state: load a fresh tile row, or shift out the next pixel
    always_comb begin
        shift_d = shift_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        if (load) begin
            shift_d = load_bits;
            fg_d    = load_fg;
            bg_d    = load_bg;
        end else begin
            shift_d = {shift_q[6:0], 1'b0};
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= 8'd0;
            fg_q    <= 3'd0;
            bg_q    <= 3'd0;
        end else begin
            shift_q <= shift_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
        end
    end

    assign pixel_bit = shift_q[7];
    assign cur_fg    = fg_q;
    assign cur_bg    = bg_q;

endmodule

// File: rtl/tile_renderer.sv
// -----------------------------------------------------------------------------
// tile_renderer
// Tile-map pixel generator. It fetches the tile code and colours for column
// c+1 from the tile RAM, then the bitmap row from the character ROM. This
// happens during the 8 clocks in which column c is on screen. The renderer
// outputs one registered rgb pixel per clock.
//   clk, reset  : pixel clock and asynchronous active-high reset
//   hpos, vpos  : raster position from the sync generator
//   display_on  : visible-area qualifier
//   ram_addr    : tile RAM address {row[4:0], col[4:0]}. Data returns 1 clk later.
//   ram_rdata   : tile word [7:0] code, [10:8] fg, [14:12] bg
//   rom_addr    : char ROM address {code, line[2:0]}. Data returns 1 clk later.
//   rom_rdata   : bitmap row, with bit 7 as the leftmost pixel
//   rgb         : pixel for hpos=h, valid one clk after h is presented
// -----------------------------------------------------------------------------
module tile_renderer
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  hpos,
    input  logic [8:0]  vpos,
    input  logic        display_on,
    output logic [9:0]  ram_addr,
    input  logic [15:0] ram_rdata,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic [2:0]  rgb
);

    // Fetch target decode
    logic       fetch_window;
    logic       fetch_active;
    logic       in_prefetch;
    logic [4:0] fetch_col;
    logic [8:0] fetch_line;
    logic [2:0] phase;

    // Fetch pipeline registers
    logic [9:0]  ram_addr_q;
    logic [9:0]  ram_addr_d;
    logic [10:0] rom_addr_q;
    logic [10:0] rom_addr_d;
    tile_attr_t  next_attr_q;
    tile_attr_t  next_attr_d;
    logic [7:0]  next_bits_q;
    logic [7:0]  next_bits_d;

    // Output gating: the output stays 0 until a full column-0 prefetch
    // has been loaded after reset.
    logic primed_q;
    logic primed_d;

    logic [2:0] rgb_q;
    logic [2:0] rgb_d;

    // Shifter interface
    logic       shift_load;
    logic       pixel_bit;
    logic [2:0] cur_fg;
    logic [2:0] cur_bg;

    // Spare tile-word bits, kept only to document that they are ignored
    logic unused_tile_bits;
    assign unused_tile_bits = ram_rdata[15] ^ ram_rdata[11];

    // Select what to fetch at this raster position, and the pipeline phase
    always_comb begin
        fetch_window = 1'b0;
        in_prefetch  = 1'b0;
        fetch_col    = 5'd0;
        fetch_line   = vpos;
        phase        = hpos[2:0];
        if (hpos < 9'(H_DISPLAY)) begin
            // Column c is on screen, so fetch c+1. Tile 31 wraps to 0 and
            // that fetch is never shown.
            fetch_window = 1'b1;
            fetch_col    = hpos[7:3] + 5'd1;
            fetch_line   = vpos;
            phase        = hpos[2:0];
        end else if (hpos >= PREFETCH_START) begin
            // Column 0 of the next line. The phase is re-based so that
            // phase 7 falls on the last clock of the line.
            fetch_window = 1'b1;
            in_prefetch  = 1'b1;
            fetch_col    = 5'd0;
            fetch_line   = next_line(vpos);
            phase        = hpos[2:0] - PREFETCH_PHASE;
        end else begin
            fetch_window = 1'b0;
            in_prefetch  = 1'b0;
            fetch_col    = 5'd0;
            fetch_line   = vpos;
            phase        = hpos[2:0];
        end
    end

    // Lines outside the visible rows never fetch. This keeps tile RAM words
    // 960..1023 unaddressed, and blank lines leave the address registers alone.
    assign fetch_active = fetch_window && (fetch_line < 9'(V_DISPLAY));

    // Per-phase fetch pipeline: RAM address, tile word, ROM address, bitmap, load
    always_comb begin
        ram_addr_d  = ram_addr_q;
        rom_addr_d  = rom_addr_q;
        next_attr_d = next_attr_q;
        next_bits_d = next_bits_q;
        primed_d    = primed_q;
        shift_load  = 1'b0;
        if (fetch_active) begin
            case (phase)
                3'd0: begin
                    ram_addr_d = {fetch_line[7:3], fetch_col};
                end
                3'd2: begin
                    next_attr_d.code = ram_rdata[CODE_MSB:CODE_LSB];
                    next_attr_d.fg   = ram_rdata[FG_MSB:FG_LSB];
                    next_attr_d.bg   = ram_rdata[BG_MSB:BG_LSB];
                end
                3'd3: begin
                    rom_addr_d = {next_attr_q.code, fetch_line[2:0]};
                end
                3'd5: begin
                    next_bits_d = rom_rdata;
                end
                3'd7: begin
                    shift_load = 1'b1;
                    if (in_prefetch) begin
                        primed_d = 1'b1;
                    end else begin
                        primed_d = primed_q;
                    end
                end
                default: begin
                    shift_load = 1'b0;
                end
            endcase
        end else begin
            shift_load = 1'b0;
        end
    end

    // Pixel colour: foreground or background, blanked outside the visible area
    always_comb begin
        rgb_d = 3'd0;
        if (display_on && primed_q) begin
            if (pixel_bit) begin
                rgb_d = cur_fg;
            end else begin
                rgb_d = cur_bg;
            end
        end else begin
            rgb_d = 3'd0;
        end
    end

    // Fetch pipeline and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr_q  <= 10'd0;
            rom_addr_q  <= 11'd0;
            next_attr_q <= '{code: 8'd0, fg: 3'd0, bg: 3'd0};
            next_bits_q <= 8'd0;
            primed_q    <= 1'b0;
            rgb_q       <= 3'd0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            rom_addr_q  <= rom_addr_d;
            next_attr_q <= next_attr_d;
            next_bits_q <= next_bits_d;
            primed_q    <= primed_d;
            rgb_q       <= rgb_d;
        end
    end

    tile_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (shift_load),
        .load_bits (next_bits_q),
        .load_fg   (next_attr_q.fg),
        .load_bg   (next_attr_q.bg),
        .pixel_bit (pixel_bit),
        .cur_fg    (cur_fg),
        .cur_bg    (cur_bg)
    );

    assign ram_addr = ram_addr_q;
    assign rom_addr = rom_addr_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_tile_renderer.sv
// -----------------------------------------------------------------------------
// tb_tile_renderer
// The bench drives raster scans over randomised tile RAM and char ROM
// contents, plus directed tiles. It compares rgb on every clock against a
// pixel model. The model looks each pixel up directly from the RAM/ROM
// contents, using the tile-map rules.
// -----------------------------------------------------------------------------
module tb_tile_renderer;

    localparam int HD = 256;
    localparam int HT = 309;
    localparam int VD = 240;
    localparam int VT = 262;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        display_on;
    logic [9:0]  ram_addr;
    logic [15:0] ram_rdata;
    logic [10:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic [2:0]  rgb;

    logic [15:0] ram_mem [0:1023];
    logic [7:0]  rom_mem [0:2047];

    logic [2:0]  line_rgb      [0:HT-1];
    logic [9:0]  line_ram_addr [0:HT-1];

    int vectors     = 0;
    int miscompares = 0;
    bit model_primed = 1'b0;

    always #5 clk = ~clk;

    // Synchronous memories with one clock of read latency
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        rom_rdata <= rom_mem[rom_addr];
    end

    tile_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .rgb        (rgb)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Colour of screen pixel (h, v) straight from the tile map
    function automatic logic [2:0] ref_pixel(input int h, input int v);
        logic [15:0] word;
        logic [7:0]  bits;
        int          idx;
        if (h >= HD || v >= VD) return 3'd0;
        word = ram_mem[(v / 8) * 32 + (h / 8)];
        idx  = int'(word[7:0]) * 8 + (v % 8);
        bits = rom_mem[idx];
        return bits[7 - (h % 8)] ? word[10:8] : word[14:12];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) ram_mem[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        ram_mem[0]           = 16'h7141;
        rom_mem[8'h41 * 8]   = 8'hF0;
        ram_mem[29 * 32 + 31] = 16'h2300;
        rom_mem[7]           = 8'h01;
    endtask

    // One raster line. Optionally pulse reset or drop display_on at one hpos.
    task automatic run_line(input int v, input bit check_en, input int rst_at, input int drop_at);
        logic [2:0] exp;
        int         nl;
        for (int h = 0; h < HT; h++) begin
            hpos       = 9'(h);
            vpos       = 9'(v);
            display_on = (h < HD) && (v < VD) && (h != drop_at);
            if (h == rst_at) begin
                reset = 1'b1;
                #1;
                chk("async_reset_rgb", {13'd0, rgb}, 16'd0);
                chk("async_reset_ram_addr", {6'd0, ram_addr}, 16'd0);
                chk("async_reset_rom_addr", {5'd0, rom_addr}, 16'd0);
                model_primed = 1'b0;
                reset = 1'b0;
            end
            @(posedge clk);
            #1;
            exp = (model_primed && h != drop_at) ? ref_pixel(h, v) : 3'd0;
            line_rgb[h]      = rgb;
            line_ram_addr[h] = ram_addr;
            if (check_en) chk($sformatf("pixel v%0d h%0d", v, h), {13'd0, rgb}, {13'd0, exp});
            nl = (v == VT - 1) ? 0 : v + 1;
            if (h == HT - 1 && nl < VD) model_primed = 1'b1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        hpos       = 9'd0;
        vpos       = 9'd0;
        display_on = 1'b0;
        fill_random();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rgb", {13'd0, rgb}, 16'd0);
        chk("reset_ram_addr", {6'd0, ram_addr}, 16'd0);
        chk("reset_rom_addr", {5'd0, rom_addr}, 16'd0);
        reset = 1'b0;

        // Last line of the frame prefetches line 0, then the top rows follow
        run_line(VT - 1, 1'b1, -1, -1);
        run_line(0, 1'b1, -1, -1);
        for (int i = 0; i < 4; i++) chk($sformatf("line0_fg h%0d", i), {13'd0, line_rgb[i]}, 16'd1);
        for (int i = 4; i < 8; i++) chk($sformatf("line0_bg h%0d", i), {13'd0, line_rgb[i]}, 16'd7);
        for (int v = 1; v < 5; v++) run_line(v, 1'b1, -1, -1);

        // Reset in the middle of line 5; line 6 must be fully correct
        run_line(5, 1'b1, 100, -1);
        run_line(6, 1'b1, -1, -1);

        // display_on dropped for one pixel on line 7
        run_line(7, 1'b1, -1, 50);
        chk("display_drop", {13'd0, line_rgb[50]}, 16'd0);
        run_line(8, 1'b1, -1, -1);

        // New random contents, then a jump into the middle of the screen
        fill_random();
        run_line(99, 1'b0, -1, -1);
        for (int v = 100; v < 108; v++) run_line(v, 1'b1, -1, -1);

        // Bottom rows, including the last tile of the screen
        run_line(236, 1'b0, -1, -1);
        for (int v = 237; v < 242; v++) begin
            run_line(v, 1'b1, -1, -1);
            if (v == VD - 1) begin
                chk("last_tile_h255", {13'd0, line_rgb[255]}, 16'd3);
                chk("last_tile_h256", {13'd0, line_rgb[256]}, 16'd0);
            end
        end

        // Frame wrap: the address holds through the blank lines, then prefetches word 0
        run_line(VT - 2, 1'b1, -1, -1);
        run_line(VT - 1, 1'b1, -1, -1);
        chk("wrap_hold_addr", {6'd0, line_ram_addr[HT - 9]}, 16'd928);
        chk("wrap_prefetch_addr", {6'd0, line_ram_addr[HT - 8]}, 16'd0);
        for (int v = 0; v < 3; v++) run_line(v, 1'b1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
